// File: rtl/des_key_sched_iter.sv
// Iterative DES key schedule: one 56-bit C/D register pair rotated in place,
// producing the 16 round subkeys one per valid/ready handshake, in either
// encrypt (K1..K16, left rotations) or decrypt (K16..K1, right rotations) order.
module des_key_sched_iter #(
    parameter int PARITY_CHECK = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] key_in,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic        decrypt,
    output logic [47:0] sk_out,
    output logic [3:0]  sk_round,
    output logic        sk_last,
    output logic        sk_valid,
    input  logic        sk_ready,
    output logic        key_parity_err
);

    // FIPS 46-3 permuted choice tables, 1-based bit numbers (bit 1 = MSB).
    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    typedef enum logic [1:0] {
        S_IDLE,
        S_GEN,
        S_OUT
    } state_t;

    function automatic logic [55:0] f_pc1(input logic [63:0] k);
        logic [55:0] r;
        logic [5:0]  idx;
        r = '0;
        for (int unsigned i = 0; i < 56; i++) begin
            idx = 6'(64 - PC1[i]);
            r   = {r[54:0], k[idx]};
        end
        return r;
    endfunction

    function automatic logic [47:0] f_pc2(input logic [55:0] cd);
        logic [47:0] r;
        logic [5:0]  idx;
        r = '0;
        for (int unsigned i = 0; i < 48; i++) begin
            idx = 6'(56 - PC2[i]);
            r   = {r[46:0], cd[idx]};
        end
        return r;
    endfunction

    // Per-step rotation amount. Decrypt step 0 is a zero rotation because
    // K16 uses C0/D0 directly (the encrypt shifts sum to a full 28).
    function automatic logic [1:0] f_amt(input logic [3:0] n, input logic dir);
        logic       single;
        logic [1:0] a;
        single = (n == 4'd0) || (n == 4'd1) || (n == 4'd8) || (n == 4'd15);
        a      = single ? 2'd1 : 2'd2;
        if (dir && (n == 4'd0))
            a = 2'd0;
        return a;
    endfunction

    function automatic logic [27:0] f_rot(input logic [27:0] v, input logic [1:0] amt,
                                          input logic dir);
        logic [27:0] r;
        case ({dir, amt})
            3'b001:  r = {v[26:0], v[27]};
            3'b010:  r = {v[25:0], v[27:26]};
            3'b101:  r = {v[0], v[27:1]};
            3'b110:  r = {v[1:0], v[27:2]};
            default: r = v;
        endcase
        return r;
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_key_ready;
    logic        r_sk_valid;
    logic [27:0] r_c;
    logic [27:0] r_d;
    logic [3:0]  r_n;
    logic        r_dir;
    logic [47:0] r_sk;
    logic [3:0]  r_round;
    logic        r_last;
    logic        r_parity_err;

    logic        w_load;
    logic        w_step;
    logic        w_done;
    logic [55:0] w_pc1;
    logic [3:0]  w_rot_n;
    logic [1:0]  w_amt;
    logic [27:0] w_rot_c;
    logic [27:0] w_rot_d;
    logic [47:0] w_sk;
    logic [7:0]  w_byte_even;
    logic        w_parity_err;

    // Next-state decode and datapath strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (key_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_GEN;
                end
            end
            S_GEN: begin
                w_step      = 1'b1;
                w_state_nxt = S_OUT;
            end
            S_OUT: begin
                if (sk_ready) begin
                    if (r_n == 4'd15) begin
                        w_done      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_step = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Rotation/PC-2 path; the GEN cycle uses step n, an advance uses step n+1.
    always_comb begin
        w_pc1   = f_pc1(key_in);
        w_rot_n = (r_state == S_GEN) ? r_n : (r_n + 4'd1);
        w_amt   = f_amt(w_rot_n, r_dir);
        w_rot_c = f_rot(r_c, w_amt, r_dir);
        w_rot_d = f_rot(r_d, w_amt, r_dir);
        w_sk    = f_pc2({w_rot_c, w_rot_d});
    end

    // Per-byte odd-parity check on the incoming key.
    always_comb begin
        w_byte_even = '0;
        for (int unsigned b = 0; b < 8; b++)
            w_byte_even[b] = ~(^key_in[b*8 +: 8]);
        w_parity_err = (PARITY_CHECK != 0) && (|w_byte_even);
    end

    // State register plus registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_key_ready <= 1'b1;
            r_sk_valid  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_key_ready <= (w_state_nxt == S_IDLE);
            r_sk_valid  <= (w_state_nxt == S_OUT);
        end
    end

    // C/D, step counter and subkey output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c          <= '0;
            r_d          <= '0;
            r_n          <= '0;
            r_dir        <= 1'b0;
            r_sk         <= '0;
            r_round      <= '0;
            r_last       <= 1'b0;
            r_parity_err <= 1'b0;
        end else if (w_load) begin
            r_c          <= w_pc1[55:28];
            r_d          <= w_pc1[27:0];
            r_n          <= '0;
            r_dir        <= decrypt;
            r_parity_err <= w_parity_err;
        end else if (w_step) begin
            r_c     <= w_rot_c;
            r_d     <= w_rot_d;
            r_n     <= w_rot_n;
            r_sk    <= w_sk;
            r_round <= r_dir ? (4'd15 - w_rot_n) : w_rot_n;
            r_last  <= (w_rot_n == 4'd15);
        end else if (w_done) begin
            r_last <= 1'b0;
        end
    end

    assign key_ready      = r_key_ready;
    assign sk_valid       = r_sk_valid;
    assign sk_out         = r_sk;
    assign sk_round       = r_round;
    assign sk_last        = r_last;
    assign key_parity_err = r_parity_err;

endmodule

// File: tb/tb_des_key_sched_iter.sv
// Bench for des_key_sched_iter: randomized loads and backpressure, expected
// subkeys from a cumulative-shift DES key-schedule model, scoreboard checking.
module tb_des_key_sched_iter;

    localparam logic [63:0] KEY_STD = 64'h133457799BBCDFF1;

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    typedef struct packed {
        logic [47:0] sk;
        logic [3:0]  rnd;
        logic        last;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [63:0] key_in;
    logic        key_valid;
    logic        key_ready;
    logic        decrypt;
    logic [47:0] sk_out;
    logic [3:0]  sk_round;
    logic        sk_last;
    logic        sk_valid;
    logic        sk_ready;
    logic        key_parity_err;

    int   tests;
    int   fails;
    int   hs_count;
    exp_t sb[$];
    exp_t act_log[$];
    logic [47:0] enc_sk [16];

    des_key_sched_iter #(.PARITY_CHECK(1)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .key_in         (key_in),
        .key_valid      (key_valid),
        .key_ready      (key_ready),
        .decrypt        (decrypt),
        .sk_out         (sk_out),
        .sk_round       (sk_round),
        .sk_last        (sk_last),
        .sk_valid       (sk_valid),
        .sk_ready       (sk_ready),
        .key_parity_err (key_parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Ki computed directly: Ci/Di = C0/D0 rotated left by the cumulative shift.
    function automatic logic [47:0] ref_subkey(input logic [63:0] key, input int rnd);
        logic [27:0] c0, d0, c, d;
        logic [55:0] cd;
        logic [47:0] k;
        int s;
        for (int i = 0; i < 28; i++) begin
            c0[27 - i] = key[6'(64 - PC1_T[i])];
            d0[27 - i] = key[6'(64 - PC1_T[28 + i])];
        end
        s = 0;
        for (int i = 0; i < rnd; i++) s += SHIFTS[i];
        s  = s % 28;
        c  = (c0 << s) | (c0 >> (28 - s));
        d  = (d0 << s) | (d0 >> (28 - s));
        cd = {c, d};
        for (int i = 0; i < 48; i++) k[47 - i] = cd[6'(56 - PC2_T[i])];
        return k;
    endfunction

    function automatic logic ref_parity_err(input logic [63:0] key);
        logic e = 1'b0;
        for (int b = 0; b < 8; b++)
            if (($countones(key[b*8 +: 8]) % 2) == 0) e = 1'b1;
        return e;
    endfunction

    // Pops the scoreboard on each handshake and checks output stability in stalls.
    task automatic monitor();
        exp_t e;
        exp_t prev;
        logic prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall)
                    chk("stall_hold", {sk_valid, sk_out, sk_round, sk_last}, {1'b1, prev});
                if (sk_valid && sk_ready) begin
                    act_log.push_back({sk_out, sk_round, sk_last});
                    hs_count++;
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL sb_empty: unexpected subkey %h round %0d", sk_out, sk_round);
                    end else begin
                        e = sb.pop_front();
                        chk("subkey", {sk_out, sk_round, sk_last}, e);
                    end
                end
                prev_stall = sk_valid && !sk_ready;
                prev       = {sk_out, sk_round, sk_last};
            end
        end
    endtask

    task automatic load(input logic [63:0] key, input logic dec);
        int b = 0;
        while (!key_ready && b < 100) begin
            @(posedge clk); #1;
            b++;
        end
        chk("load_ready", key_ready, 1);
        key_in    = key;
        decrypt   = dec;
        key_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
        key_in    = {$urandom, $urandom};
        decrypt   = ~dec;
    endtask

    // mode 0: sk_ready held high; 1: random sk_ready; 2: random plus an ignored load.
    task automatic run_key(input logic [63:0] key, input logic dec, input int mode, input int n_hs);
        exp_t e;
        int   base;
        int   cyc;
        logic perr;
        for (int i = 0; i < 16; i++) begin
            e.rnd  = dec ? 4'(15 - i) : 4'(i);
            e.sk   = ref_subkey(key, int'(e.rnd) + 1);
            e.last = (i == 15);
            sb.push_back(e);
        end
        perr = ref_parity_err(key);
        act_log.delete();
        load(key, dec);
        chk("gen_bubble", {key_ready, sk_valid}, 2'b00);
        chk("parity_on_load", key_parity_err, perr);
        base = hs_count;
        cyc  = 0;
        while (hs_count < base + n_hs && cyc < 400) begin
            sk_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (mode == 2 && cyc == 6) begin
                key_valid = 1'b1;
                key_in    = 64'h0;
                decrypt   = ~dec;
            end else begin
                key_valid = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) chk("first_valid_latency", sk_valid, 1);
        end
        key_valid = 1'b0;
        if (hs_count < base + n_hs) begin
            tests++;
            fails++;
            $display("FAIL handshake_timeout: %0d of %0d handshakes", hs_count - base, n_hs);
        end
        if (n_hs == 16) begin
            chk("idle_after_last", {key_ready, sk_valid, sk_last}, 3'b100);
            chk("sb_drained", sb.size(), 0);
            chk("parity_held", key_parity_err, perr);
            if (mode == 0) chk("back_to_back_cycles", cyc, 17);
        end
        sk_ready = 1'b0;
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        hs_count  = 0;
        rst_n     = 1'b0;
        key_in    = '0;
        key_valid = 1'b0;
        decrypt   = 1'b0;
        sk_ready  = 1'b0;
        fork
            monitor();
        join_none

        #22;
        chk("rst_key_ready", key_ready, 1);
        chk("rst_sk_valid", sk_valid, 0);
        chk("rst_sk_last", sk_last, 0);
        chk("rst_sk_round", sk_round, 0);
        chk("rst_sk_out", sk_out, 0);
        chk("rst_parity", key_parity_err, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Encrypt order, known answers, table of subkeys by round.
        run_key(KEY_STD, 1'b0, 0, 16);
        chk("enc_count", act_log.size(), 16);
        chk("enc_first", act_log[0], {48'h1B02EFFC7072, 4'd0, 1'b0});
        chk("enc_last", act_log[15], {48'hCB3D8B0E17F5, 4'd15, 1'b1});
        for (int i = 0; i < 16; i++) enc_sk[act_log[i].rnd] = act_log[i].sk;

        // Decrypt order must match encrypt subkeys round for round.
        run_key(KEY_STD, 1'b1, 0, 16);
        chk("dec_count", act_log.size(), 16);
        chk("dec_first", act_log[0], {48'hCB3D8B0E17F5, 4'd15, 1'b0});
        chk("dec_last", act_log[15], {48'h1B02EFFC7072, 4'd0, 1'b1});
        for (int i = 0; i < 16; i++)
            chk("dec_vs_enc", act_log[i].sk, enc_sk[act_log[i].rnd]);

        // Backpressure: one handshake per round, in order.
        run_key(KEY_STD, 1'b0, 1, 16);
        for (int i = 0; i < 16; i++) chk("bp_round_order", act_log[i].rnd, i);

        // Ignored mid-run load, then parity on the all-zero key and back.
        run_key(KEY_STD, 1'b0, 2, 16);
        run_key(64'h0, 1'b0, 1, 16);
        chk("zero_key_parity", key_parity_err, 1);
        run_key(KEY_STD, 1'b1, 1, 16);
        chk("std_key_parity", key_parity_err, 0);

        // Asynchronous reset after the 5th handshake.
        run_key(KEY_STD, 1'b0, 1, 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_outputs", {key_ready, sk_valid, sk_last, sk_out}, {3'b100, 48'h0});
        sb.delete();
        @(posedge clk);
        @(posedge clk); #1;
        chk("rst_held_idle", {key_ready, sk_valid}, 2'b10);
        rst_n = 1'b1;
        run_key(KEY_STD, 1'b1, 0, 16);
        chk("post_rst_first_round", act_log[0].rnd, 15);

        // Random keys, directions and backpressure.
        for (int r = 0; r < 6; r++)
            run_key({$urandom, $urandom}, 1'($urandom_range(0, 1)), $urandom_range(1, 2), 16);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/des_key_sched_iter.md
Name: des_key_sched_iter

Overview:
- Iterative DES key-schedule generator that produces the 16 48-bit round subkeys one per handshake.
- It runs in either direction: encrypt order K1..K16 using left rotations, or decrypt order K16..K1 using right rotations.
- It feeds the round datapath's key-mixing XOR ahead of the S-box stage.
- It replaces a 16x48 flat subkey table with a single 56-bit C/D register pair.

Parameters:
- PARITY_CHECK, 0, when 1, checks the loaded key for DES odd parity per byte and reports the result on key_parity_err.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- key_in  input  64  DES key; FIPS 46-3 bit 1 is key_in[63], parity bits are included.
- key_valid  input  1  key_in and decrypt are valid this cycle.
- key_ready  output  1  block is idle and will accept a key.
- decrypt  input  1  0 = encrypt order K1..K16, 1 = decrypt order K16..K1; sampled on load only.
- sk_out  output  48  current subkey; FIPS PC-2 output bit 1 is sk_out[47].
- sk_round  output  4  FIPS round number minus 1 of the subkey on sk_out (0..15).
- sk_last  output  1  high with the final subkey of the sequence.
- sk_valid  output  1  sk_out, sk_round and sk_last are valid.
- sk_ready  input  1  consumer accepts the subkey this cycle.
- key_parity_err  output  1  registered on load; high if any key byte has even parity. Tied to 0 when PARITY_CHECK=0.

Behaviour:
- Reset (async, rst_n=0) sets the following; the state is IDLE:
  - key_ready=1, sk_valid=0, sk_last=0
  - sk_round=0, sk_out=0, key_parity_err=0
  - C=D=0, step counter n=0
- State IDLE:
  - key_ready=1, sk_valid=0.
  - On key_valid=1 the block applies PC-1 to key_in, giving C0 (28 bits) and D0 (28 bits).
  - It latches decrypt into dir, sets n=0, updates key_parity_err, and goes to GEN.
- Rotation amounts in GEN are computed combinationally from n and dir:
  - Encrypt (dir=0): rotate C and D left by L(n), with L = 1 for n in {0,1,8,15}, else 2.
  - Decrypt (dir=1): rotate right by R(n), with R = 0 for n=0, 1 for n in {1,8,15}, else 2.
- GEN entry cycle: register the rotated C/D and sk_out = PC-2(rotated C||D). Go to OUT.
- Latency: key accepted at edge t gives the first sk_valid=1 after edge t+1 (one-cycle bubble).
- State OUT:
  - Outputs: sk_valid=1, key_ready=0.
  - sk_round = n for encrypt and 15-n for decrypt.
  - sk_last = (n==15).
- Output hold rule: sk_out, sk_round and sk_last stay stable while sk_valid=1 and sk_ready=0, for any number of stall cycles.
- Advance within OUT: when sk_valid & sk_ready and n<15, set n=n+1, register the next rotated C/D and sk_out in the same edge, and stay in OUT.
  - The result is back-to-back subkeys with no bubble when sk_ready is held high.
- Termination: when sk_valid & sk_ready and n==15, go to IDLE with sk_valid=0, sk_last=0, key_ready=1 on the next cycle.
- Cumulative rotation: after 16 subkeys, C/D have rotated a total of 28 positions, which is identity.
- key_valid while key_ready=0 is ignored; there is no queueing and no effect on the running sequence.
- decrypt is sampled only at load; changing it mid-sequence has no effect.
- Async reset mid-sequence aborts immediately to the reset values; no partial subkey is presented afterwards.
- key_parity_err is held until the next accepted key. A parity error is informational only; generation proceeds normally.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Encrypt order: key 0x133457799BBCDFF1, decrypt=0, sk_ready=1.
  - Expect 16 consecutive subkeys.
  - First: sk_round=0, sk_out=0x1B02EFFC7072.
  - Last: sk_round=15, sk_out=0xCB3D8B0E17F5, sk_last=1.
  - key_ready=1 on the following cycle.
- Decrypt order: same key, decrypt=1.
  - First: sk_out=0xCB3D8B0E17F5, sk_round=15.
  - 16th: sk_out=0x1B02EFFC7072, sk_round=0, sk_last=1.
  - Every subkey must equal the encrypt run's subkey with the same sk_round.
- Backpressure: encrypt run with sk_ready toggled pseudo-randomly.
  - Outputs must stay stable during stalls.
  - Exactly 16 handshakes, no duplicated or skipped sk_round.
- Ignored load and parity, with PARITY_CHECK=1:
  - Pulse key_valid with key 0x0000000000000000 mid-run → current sequence unchanged.
  - After the run, load 0x0000000000000000 → key_parity_err=1.
  - Reload 0x133457799BBCDFF1 → key_parity_err=0.
- Reset mid-operation: assert rst_n=0 after the 5th handshake → sk_valid=0 and key_ready=1 immediately (asynchronous).
  - After release, a new decrypt load starts again at sk_round=15.
